// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter that runs one data_bus access at a time.
// The winner's payload is latched, driven for ACCESS_CYCLES cycles, then the response is returned with a one-cycle ack.
module data_bus_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [1:0]  m0_len,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [1:0]  m1_len,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        bus_rw,
    output logic [1:0]  bus_len,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write,
    input  logic [31:0] bus_read,
    input  logic        bus_exception,
    output logic        busy
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic              rw;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } payload_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    payload_t          bus_q, bus_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic              err_q, err_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;

    payload_t          m0_pl_c, m1_pl_c;
    logic              pick_m1_c;

    assign m0_pl_c = {m0_rw, m0_len, m0_addr, m0_wdata};
    assign m1_pl_c = {m1_rw, m1_len, m1_addr, m1_wdata};

    // On contention the port that did not win last time gets the bus.
    assign pick_m1_c = m1_req & (~m0_req | ~last_grant_q);

    // Next-state and registered-output logic; bus_q holds the payload only while in ACCESS.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        bus_d        = bus_q;
        resp_d       = resp_q;
        err_d        = err_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = pick_m1_c;
                    bus_d   = pick_m1_c ? m1_pl_c : m0_pl_c;
                    cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                    busy_d  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    resp_d  = bus_q.rw ? '0 : bus_read;
                    err_d   = bus_exception;
                    bus_d   = '0;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                bus_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            bus_q        <= '0;
            resp_q       <= '0;
            err_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            bus_q        <= bus_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = resp_q;
    assign m1_rdata  = resp_q;
    assign m0_err    = err_q;
    assign m1_err    = err_q;
    assign bus_rw    = bus_q.rw;
    assign bus_len   = bus_q.len;
    assign bus_addr  = bus_q.addr;
    assign bus_write = bus_q.wdata;
    assign busy      = busy_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized scoreboard bench for data_bus_arbiter at ACCESS_CYCLES = 1 and 4,
// with a small data_bus model (RAM below 0x400, LED at 0x2000, everything else faults).
module tb_data_bus_arbiter;
    localparam int unsigned N_OPS    = 40;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned MAX_CYC  = 4000;
    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int finished = 0;

    task automatic check(input string name, input int unsigned dut,
                         input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h", name, dut, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input int unsigned dut);
        total++;
        bad++;
        $display("FAIL %s dut%0d: got no completion, want completion", name, dut);
    endtask

    task automatic finish_one();
        finished++;
    endtask

    function automatic logic mapped(input logic [31:0] a);
        return (a[31:10] == 22'd0) || (a == LED_ADDR);
    endfunction

    function automatic logic [31:0] seed_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : ((32'(i) * 32'h0101_0101) ^ 32'h5A5A_0F0F);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned AC = (g == 0) ? 1 : 4;

        logic        rst_n;
        logic        req [2];
        logic        rw [2];
        logic [1:0]  len [2];
        logic [31:0] addr [2];
        logic [31:0] wdata [2];
        logic        ack [2];
        logic [31:0] rdata [2];
        logic        err [2];
        logic        bus_rw, bus_exception, busy;
        logic [1:0]  bus_len;
        logic [31:0] bus_addr, bus_write, bus_read;
        logic [31:0] mem [256];
        logic [31:0] led;

        data_bus_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req(req[0]), .m0_rw(rw[0]), .m0_len(len[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
            .m0_ack(ack[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
            .m1_req(req[1]), .m1_rw(rw[1]), .m1_len(len[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
            .m1_ack(ack[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
            .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
            .bus_read(bus_read), .bus_exception(bus_exception), .busy(busy)
        );

        // Combinational data_bus read side.
        always_comb begin
            bus_exception = !mapped(bus_addr);
            if (bus_addr == LED_ADDR) bus_read = led;
            else if (mapped(bus_addr)) bus_read = mem[bus_addr[9:2]];
            else bus_read = 32'h0;
        end

        initial begin : bus_model
            led = 32'h0;
            for (int i = 0; i < 256; i++) mem[i] = seed_word(i);
            forever begin
                @(negedge clk);
                if (bus_rw) begin
                    if (bus_addr == LED_ADDR) led = bus_write;
                    else if (mapped(bus_addr)) mem[bus_addr[9:2]] = bus_write;
                end
            end
        end

        // Transaction-level reference: one access at a time, AC drive cycles plus one ack cycle.
        int unsigned left;
        logic        win, last;
        logic        m_rw;
        logic [1:0]  m_len;
        logic [31:0] m_addr, m_wdata;
        logic [31:0] smem [256];
        logic [31:0] sled;
        logic [32:0] exp0 [$];
        logic [32:0] exp1 [$];

        initial begin : ref_model
            logic [31:0] e_data;
            logic        e_err;
            logic [7:0]  idx;
            for (int i = 0; i < 256; i++) smem[i] = seed_word(i);
            sled = 32'h0;
            left = 0; last = 1'b1; win = 1'b0;
            m_rw = 1'b0; m_len = 2'd0; m_addr = 32'h0; m_wdata = 32'h0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    left = 0;
                    last = 1'b1;
                    exp0.delete();
                    exp1.delete();
                end else if (left != 0) begin
                    left--;
                    if (left == 0) last = win;
                end else if (req[0] || req[1]) begin
                    win     = (req[0] && req[1]) ? ~last : req[1];
                    m_rw    = rw[win];
                    m_len   = len[win];
                    m_addr  = addr[win];
                    m_wdata = wdata[win];
                    left    = AC + 1;
                    idx     = m_addr[9:2];
                    e_err   = !mapped(m_addr);
                    if (m_rw) begin
                        e_data = 32'h0;
                        if (m_addr == LED_ADDR) sled = m_wdata;
                        else if (!e_err) smem[idx] = m_wdata;
                    end else if (m_addr == LED_ADDR) begin
                        e_data = sled;
                    end else begin
                        e_data = e_err ? 32'h0 : smem[idx];
                    end
                    if (win) exp1.push_back({e_err, e_data});
                    else exp0.push_back({e_err, e_data});
                end
            end
        end

        initial begin : monitor
            logic [69:0] want;
            logic [32:0] e;
            forever begin
                @(negedge clk);
                want = '0;
                if (left != 0) begin
                    want[69] = 1'b1;
                    if (left == 1) begin
                        if (win) want[67] = 1'b1;
                        else want[68] = 1'b1;
                    end else begin
                        want[66:0] = {m_rw, m_len, m_addr, m_wdata};
                    end
                end
                check("cycle", g, 128'({busy, ack[0], ack[1], bus_rw, bus_len, bus_addr, bus_write}),
                      128'(want));
                if (ack[0]) begin
                    if (exp0.size() == 0) report_fail("m0_unexpected_ack", g);
                    else begin
                        e = exp0.pop_front();
                        check("m0_resp", g, 128'({err[0], rdata[0]}), 128'(e));
                    end
                end
                if (ack[1]) begin
                    if (exp1.size() == 0) report_fail("m1_unexpected_ack", g);
                    else begin
                        e = exp1.pop_front();
                        check("m1_resp", g, 128'({err[1], rdata[1]}), 128'(e));
                    end
                end
            end
        end

        // First few ops per port are fixed scenarios; the rest are random.
        task automatic issue(input int m, input int unsigned n);
            int unsigned sel;
            sel      = $urandom_range(7, 0);
            req[m]   = 1'b1;
            len[m]   = 2'($urandom_range(3, 0));
            wdata[m] = $urandom;
            rw[m]    = 1'($urandom_range(1, 0));
            if (sel == 0) addr[m] = LED_ADDR;
            else if (sel == 1) addr[m] = 32'hF000_0000 | {14'd0, 16'($urandom), 2'b00};
            else addr[m] = {22'd0, 8'($urandom), 2'b00};
            if (m == 1 && n == 0) begin
                rw[m] = 1'b0; addr[m] = 32'h0000_0040;
            end else if (m == 1 && n == 1) begin
                rw[m] = 1'b1; addr[m] = LED_ADDR; wdata[m] = 32'h0000_00A5;
            end else if (m == 0 && n == 1) begin
                rw[m] = 1'b0; addr[m] = 32'hF000_0000;
            end else if (m == 0 && (n == 0 || n == 2)) begin
                rw[m] = 1'b0; addr[m] = {22'd0, 8'($urandom), 2'b00};
            end
        endtask

        initial begin : driver
            int unsigned ops [2];
            int unsigned gap [2];
            int unsigned wt [2];
            int unsigned cyc;
            int unsigned w;
            logic [1:0]  first;
            for (int m = 0; m < 2; m++) begin
                req[m] = 1'b0; rw[m] = 1'b0; len[m] = 2'd0; addr[m] = 32'h0; wdata[m] = 32'h0;
                ops[m] = 0; gap[m] = 0; wt[m] = 0;
            end
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            cyc = 0;
            while ((ops[0] < N_OPS || ops[1] < N_OPS || req[0] || req[1]) && cyc < MAX_CYC) begin
                @(negedge clk);
                cyc++;
                for (int m = 0; m < 2; m++) begin
                    if (req[m]) begin
                        if (ack[m]) begin
                            if (m == 1 && ops[m] == 1) check("led_a5", g, 128'(led), 128'(32'hA5));
                            ops[m]++;
                            wt[m] = 0;
                            if (ops[m] < N_OPS && $urandom_range(1, 0) == 1) issue(m, ops[m]);
                            else begin
                                req[m] = 1'b0;
                                gap[m] = $urandom_range(3, 0);
                            end
                        end else begin
                            wt[m]++;
                            if (wt[m] > TIMEOUT) begin
                                report_fail("ack_timeout", g);
                                req[m] = 1'b0;
                                ops[m] = N_OPS;
                            end
                        end
                    end else if (gap[m] != 0) begin
                        gap[m]--;
                    end else if (ops[m] < N_OPS) begin
                        issue(m, ops[m]);
                    end
                end
            end
            if (cyc >= MAX_CYC) report_fail("traffic_budget", g);

            // Abort an access with reset, then both ports contend again.
            repeat (3) @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                req[m] = 1'b1; rw[m] = 1'b0; len[m] = 2'd2; addr[m] = 32'h100 + 32'(m * 4);
            end
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 check("reset_abort", g, 128'({busy, ack[0], ack[1], bus_rw, bus_len, bus_addr,
                                             bus_write, err[0], rdata[0]}), 128'(0));
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b1;
            first = 2'b00;
            w = 0;
            while (first == 2'b00 && w < TIMEOUT) begin
                @(negedge clk);
                w++;
                first = {ack[0], ack[1]};
            end
            check("first_after_reset", g, 128'(first), 128'(2'b10));
            req[0] = 1'b0;
            w = 0;
            while (!ack[1] && w < TIMEOUT) begin
                @(negedge clk);
                w++;
            end
            if (!ack[1]) report_fail("m1_after_reset", g);
            req[1] = 1'b0;
            repeat (3) @(negedge clk);
            check("led_final", g, 128'(led), 128'(sled));
            finish_one();
        end
    end

    initial begin : top_ctl
        int unsigned w;
        w = 0;
        while (finished < 2 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (finished < 2) report_fail("global_timeout", 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter and access sequencer in front of the combinational `data_bus`. It shares the bus between the instruction-fetch port (m0) and the load/store port (m1) using round-robin arbitration, and latches the winner's request. It drives the request onto the bus for a programmable number of cycles, then registers the read data and exception and returns them with a one-cycle acknowledge.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 1: cycles the bus is driven before sampling; legal range 1–15 (4-bit counter).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held with payload until that port's ack.
- `m0_rw`, `m1_rw`  in  1  1 = write, 0 = read.
- `m0_len`, `m1_len`  in  2  access size code, passed through to `data_bus` `len`.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  response data; both driven from one shared response register; valid only while own ack is high.
- `m0_err`, `m1_err`  out  1  latched bus exception; shared register; qualified by own ack.
- `bus_rw`  out  1  to `data_bus` `rw`.
- `bus_len`  out  2  to `data_bus` `len`.
- `bus_addr`  out  32  to `data_bus` `addr`.
- `bus_write`  out  32  to `data_bus` `write`.
- `bus_read`  in  32  from `data_bus` `read`.
- `bus_exception`  in  1  from `data_bus` `exception`.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- FSM states:
  - IDLE: if any `req` is high, pick the winner, latch `rw`/`len`/`addr`/`wdata`, load counter = `ACCESS_CYCLES-1`, go to ACCESS.
  - ACCESS: drive the latched payload onto `bus_*`. If counter == 0, sample `bus_read` and `bus_exception` into the response register and go to RESP; else decrement the counter.
  - RESP: pulse the winner's ack, set `last_grant` = winner, go to IDLE.
- Response data: for writes the response data is forced to 0; `err` is still sampled.
- Bus outputs outside ACCESS: `bus_rw`=0, `bus_len`=0, `bus_addr`=0, `bus_write`=0. No write strobe can occur outside ACCESS, so the LED register in `data_bus` is never disturbed by idle states.
- Round-robin arbitration:
  - Only one `req` high: that port wins.
  - Both high: the port ≠ `last_grant` wins.
  - `last_grant` resets to 1, so m0 wins the first simultaneous contest.
- Payload changes after latching are ignored until the next IDLE.
- `req` dropped while the port's access is in flight is a protocol violation. The latched access still completes and its ack still pulses.
- The ack goes only to the latched winner; the other port's ack stays 0.
- Exactly one access is in flight at a time; there are no queues.

## Timing
- Reset (`rst_n` low, asynchronous): state=IDLE, counter=0, `last_grant`=1, response register=0, err=0. All acks 0, all `bus_*` 0, `busy` 0. Reset mid-access aborts the access and no ack is issued.
- Cycle numbering: `req` is sampled at edge E0 (IDLE).
  - ACCESS spans cycles E1..E`ACCESS_CYCLES`.
  - Bus sampling occurs at edge E`ACCESS_CYCLES`, i.e. the end of the last ACCESS cycle.
  - Ack is high during the cycle after that edge (RESP).
- Latency: req-sample to ack = `ACCESS_CYCLES`+1 cycles. Issue interval = `ACCESS_CYCLES`+2 cycles per access.
- Back-to-back: a master seeing its ack may present new payload at the same edge. That payload is sampled in the following IDLE cycle.
- The response register holds its value until the next sampling edge, but is only guaranteed while ack is high.

## Test plan
- Single read, `ACCESS_CYCLES`=1: m1 reads `addr` in data region with ram preloaded 0xDEADBEEF -> `bus_addr` matches for exactly 1 cycle; `m1_ack` pulses 2 cycles after sampling with `m1_rdata`=0xDEADBEEF, `m1_err`=0; `m0_ack` stays 0.
- Contention: both `req` high continuously from reset, 4 accesses each -> grant order m0, m1, m0, m1, …; no port gets two consecutive grants while the other waits.
- Wait states, `ACCESS_CYCLES`=4: m0 read -> `bus_*` stable for 4 cycles; ack at cycle 5 after sampling; `busy` high for 5 cycles.
- Write to LED address with data 0xA5 from m1 -> `bus_rw`=1 for the ACCESS window only; `led`=0xA5 afterwards; `m1_rdata`=0; `bus_rw`=0 in IDLE/RESP.
- Exception: m0 read of an unmapped address driving `bus_exception`=1 -> `m0_err`=1 during ack. A following good access returns err=0.
- Reset mid-ACCESS (`ACCESS_CYCLES`=4, reset in 2nd cycle) -> all outputs 0 immediately, no ack. After release with m0 and m1 both requesting, m0 is granted first.
